// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the dual-read register file.
//   RF_DATA_W - entry / data-bus width
//   RF_ADDR_W - address width
//   RF_DEPTH  - number of entries (2**RF_ADDR_W)
package rf_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;
    localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port of the register file, latency 1.
// Optional macro: RF_BYPASS_EN selects write-first forwarding when the write
// in the same cycle targets the address being read; otherwise read-first.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   re, raddr      - read enable and address
//   mem            - view of the storage array
//   we/waddr/wdata - write port of the same cycle (used for forwarding)
//   rdata, rvalid  - registered read data and "updated this cycle" flag
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    logic [DATA_W-1:0] rd_val;

`ifdef RF_BYPASS_EN
    always_comb begin
        rd_val = mem[raddr];
        // Write-first: a same-cycle write to this address wins over storage.
        if (we && (waddr == raddr)) begin
            rd_val = wdata;
        end
    end
`else
    // Read-first: storage still holds the old value at this edge.
    always_comb begin
        rd_val = mem[raddr];
    end

    logic unused_bypass;
    assign unused_bypass = ^{we, waddr, wdata};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= rd_val;
            end
        end
    end

endmodule

// File: rtl/rf_dual_read.sv
// rf_dual_read: 8 x 8 register file, one synchronous write port and two
// independent registered read ports (A, B) with 1-cycle latency.
// Optional macro: RF_BYPASS_EN (write-first forwarding on same-address
// read/write; default build is read-first). Storage behaves the same either way.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   we, waddr, wdata         - write port
//   re_a, raddr_a            - port A read request
//   rdata_a, rvalid_a        - port A registered result
//   re_b, raddr_b            - port B read request
//   rdata_b, rvalid_b        - port B registered result
module rf_dual_read
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset has priority, so a write presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .clk    (clk),
        .reset  (reset),
        .re     (re_a),
        .raddr  (raddr_a),
        .mem    (mem),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata_a),
        .rvalid (rvalid_a)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .clk    (clk),
        .reset  (reset),
        .re     (re_b),
        .raddr  (raddr_b),
        .mem    (mem),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata_b),
        .rvalid (rvalid_b)
    );

endmodule
